// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the binary pooling scan controller.
package pool_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, LAST, DONE} pool_state_t;

    typedef struct packed {
        logic and_b;
        logic par_b;
        logic or_b;
    } pool_res_t;

    function automatic int unsigned pool_out_dim(input int unsigned row_limit,
                                                 input int unsigned win,
                                                 input int unsigned stride);
        return (row_limit - win) / stride + 1;
    endfunction

    // Index width that stays at least one bit for degenerate single-position scans.
    function automatic int unsigned pool_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_window_eval.sv
// Combinational evaluation of one pooling window: AND, parity and OR of its pixels.
module pool_window_eval
    import pool_pkg::*;
#(
    parameter int unsigned ROW_LIMIT   = 10,
    parameter int unsigned WINDOW_SIZE = 3,
    parameter int unsigned STRIDE      = 1,
    parameter int unsigned IDX_W       = pool_idx_w(pool_out_dim(ROW_LIMIT, WINDOW_SIZE, STRIDE))
) (
    input  logic [ROW_LIMIT*ROW_LIMIT-1:0] frame_i,
    input  logic [IDX_W-1:0]               row_i,
    input  logic [IDX_W-1:0]               col_i,
    output pool_res_t                      res_o
);

    logic [ROW_LIMIT*ROW_LIMIT-1:0] shifted;
    logic                           all_b;
    logic                           xor_b;
    logic                           any_b;

    always_comb begin
        shifted = '0;
        all_b   = 1'b1;
        xor_b   = 1'b0;
        any_b   = 1'b0;
        for (int unsigned dr = 0; dr < WINDOW_SIZE; dr++) begin
            for (int unsigned dc = 0; dc < WINDOW_SIZE; dc++) begin
                shifted = frame_i >> ((32'(row_i) * STRIDE + dr) * ROW_LIMIT
                                      + 32'(col_i) * STRIDE + dc);
                all_b   = all_b & shifted[0];
                xor_b   = xor_b ^ shifted[0];
                any_b   = any_b | shifted[0];
            end
        end
        res_o       = '0;
        res_o.and_b = all_b;
        // Even-sized windows report XNOR so an all-equal window gives a fixed parity sense.
        res_o.par_b = (WINDOW_SIZE % 2 == 0) ? ~xor_b : xor_b;
        res_o.or_b  = any_b;
    end

endmodule

// File: rtl/pool_scan_ctrl.sv
// Scan sequencer for binary pooling: latches a frame and streams per-window AND/parity/OR.
// Accumulated feature maps are built only when POOL_MAP_EN is defined.
module pool_scan_ctrl
    import pool_pkg::*;
#(
    parameter int unsigned ROW_LIMIT   = 10,
    parameter int unsigned WINDOW_SIZE = 3,
    parameter int unsigned STRIDE      = 1,
    localparam int unsigned OUT_DIM    = pool_out_dim(ROW_LIMIT, WINDOW_SIZE, STRIDE),
    localparam int unsigned IDX_W      = pool_idx_w(OUT_DIM),
    localparam int unsigned MAP_W      = OUT_DIM * OUT_DIM
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [ROW_LIMIT*ROW_LIMIT-1:0] frame_in,
    output logic                           busy,
    output logic                           done,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [2:0]                     res_bits,
    output logic [IDX_W-1:0]               res_row,
    output logic [IDX_W-1:0]               res_col,
    output logic [MAP_W-1:0]               and_map,
    output logic [MAP_W-1:0]               par_map,
    output logic [MAP_W-1:0]               or_map
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_DIM - 1);

    pool_state_t                    state_q, state_d;
    logic [ROW_LIMIT*ROW_LIMIT-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]               row_q, row_d;
    logic [IDX_W-1:0]               col_q, col_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           valid_q, valid_d;
    pool_res_t                      bits_q, bits_d;
    logic [IDX_W-1:0]               rrow_q, rrow_d;
    logic [IDX_W-1:0]               rcol_q, rcol_d;

    logic                           idle;
    logic                           xfer;
    logic                           load;
    logic                           pos_last;
    logic [ROW_LIMIT*ROW_LIMIT-1:0] eval_frame;
    pool_res_t                      eval_res;

    assign idle     = (state_q == IDLE);
    assign xfer     = valid_q & res_ready;
    assign pos_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);
    // Counters rest at (0,0) in IDLE, so the first window is evaluated straight off frame_in
    // and loaded on the start edge itself.
    assign eval_frame = idle ? frame_in : frame_q;

    pool_window_eval #(
        .ROW_LIMIT  (ROW_LIMIT),
        .WINDOW_SIZE(WINDOW_SIZE),
        .STRIDE     (STRIDE),
        .IDX_W      (IDX_W)
    ) u_eval (
        .frame_i(eval_frame),
        .row_i  (row_q),
        .col_i  (col_q),
        .res_o  (eval_res)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        row_d   = row_q;
        col_d   = col_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        bits_d  = bits_q;
        rrow_d  = rrow_q;
        rcol_d  = rcol_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    frame_d = frame_in;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                    state_d = pos_last ? LAST : SCAN;
                end
            end
            SCAN: begin
                load = ~valid_q | xfer;
                if (load && pos_last) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            valid_d = 1'b1;
            bits_d  = eval_res;
            rrow_d  = row_q;
            rcol_d  = col_q;
            if (pos_last) begin
                row_d = '0;
                col_d = '0;
            end else if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            bits_q  <= '0;
            rrow_q  <= '0;
            rcol_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            row_q   <= row_d;
            col_q   <= col_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            bits_q  <= bits_d;
            rrow_q  <= rrow_d;
            rcol_q  <= rcol_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = valid_q;
    assign res_bits  = bits_q;
    assign res_row   = rrow_q;
    assign res_col   = rcol_q;

`ifdef POOL_MAP_EN
    logic [MAP_W-1:0] and_q, and_d;
    logic [MAP_W-1:0] par_q, par_d;
    logic [MAP_W-1:0] or_q, or_d;
    logic [MAP_W-1:0] hit;

    always_comb begin
        and_d = and_q;
        par_d = par_q;
        or_d  = or_q;
        hit   = MAP_W'(1'b1) << (32'(rrow_q) * OUT_DIM + 32'(rcol_q));
        if (idle && start) begin
            and_d = '0;
            par_d = '0;
            or_d  = '0;
        end else if (xfer) begin
            and_d = bits_q.and_b ? (and_q | hit) : (and_q & ~hit);
            par_d = bits_q.par_b ? (par_q | hit) : (par_q & ~hit);
            or_d  = bits_q.or_b  ? (or_q  | hit) : (or_q  & ~hit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_q <= '0;
            par_q <= '0;
            or_q  <= '0;
        end else begin
            and_q <= and_d;
            par_q <= par_d;
            or_q  <= or_d;
        end
    end

    assign and_map = and_q;
    assign par_map = par_q;
    assign or_map  = or_q;
`else
    assign and_map = '0;
    assign par_map = '0;
    assign or_map  = '0;
`endif

endmodule
